// File: rtl/dlx_pkg.sv
// Shared DLX definitions: text-segment base, word size, fetch FSM states
// and the {pc, inst} entry type carried from fetch toward decode.
package dlx_pkg;

    localparam logic [31:0] DLX_TEXT_BASE  = 32'h0040_0020;
    localparam int unsigned DLX_WORD_BYTES = 4;

    typedef enum logic {
        FETCH_IDLE,
        FETCH_ACCESS
    } fetch_state_t;

    typedef logic [31:0] inst_t;

    typedef struct packed {
        logic [31:0] pc;
        inst_t       inst;
    } fetch_entry_t;

    // Sequential fetch address; wraps naturally at 32 bits.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'(DLX_WORD_BYTES);
    endfunction

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/imem_fetch_buf.sv
// fetch_buf: small shift-register FIFO of {pc, inst} entries between the
// fetch FSM and decode. Entry 0 is always the head, so the head outputs
// come straight from flops. Push and pop in the same cycle are legal
// even when full; flush empties the buffer and wins over push/pop.
module fetch_buf
    import dlx_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t wr_entry,
    input  logic         pop,
    output logic         head_valid,
    output fetch_entry_t head,
    output logic         full
);

    localparam int EW = $bits(fetch_entry_t);

    logic [DEPTH*EW-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]    vld_q, vld_d;
    logic                placed;

    // Next buffer contents: shift out on pop, fill first free slot on push.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        mem_d  = mem_q;
        vld_d  = vld_q;
        placed = 1'b0;
        if (pop) begin
            mem_d = mem_q >> EW;
            vld_d = vld_q >> 1;
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!placed && !vld_d[i]) begin
                    mem_d[i*EW +: EW] = wr_entry;
                    vld_d[i]          = 1'b1;
                    placed            = 1'b1;
                end
            end
        end
        if (flush) begin
            vld_d = '0;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        // NOTE: the storage is reset too, because the head drives inst_o/pc_o, which must read zero out of reset.
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            mem_q <= '0;
            vld_q <= '0;
        end else begin
            mem_q <= mem_d;
            vld_q <= vld_d;
        end
    end

    assign head       = mem_q[EW-1:0];
    assign head_valid = vld_q[0];
    assign full       = vld_q[DEPTH-1];

endmodule

// File: rtl/imem_fetch.sv
// imem_fetch: DLX instruction-fetch initiator. Holds the fetch PC, runs a
// wait-state sram read FSM and hands fetched words to decode through a
// valid/ready buffer. A redirect flushes everything and restarts at the
// new PC on the next cycle.
// Build option: define IMEM_FETCH_PREFETCH_EN for a 2-entry buffer that
// keeps fetching while one word waits for decode; otherwise the buffer
// holds a single word.
module imem_fetch
    import dlx_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DLX_TEXT_BASE,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cs,
    output logic        oe,
    output logic        we,
    output logic [31:0] addr,
    output logic [31:0] din,
    input  logic [31:0] dout,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

`ifdef IMEM_FETCH_PREFETCH_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif

    localparam logic [1:0]  WAIT_LAST  = 2'(WAIT_CYCLES);
    localparam logic [31:0] RESET_ADDR = word_align(RESET_PC);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [1:0]   wait_q;
    logic         cs_q;
    logic         oe_q;

    logic         buf_full;
    logic         buf_valid;
    fetch_entry_t buf_head;
    fetch_entry_t wr_entry;
    logic         pop;
    logic         slot_free;
    logic         complete;

    // A pop in this cycle frees a slot for the word being captured now.
    assign pop       = inst_valid_o && inst_ready_i && !redirect_i;
    assign slot_free = !buf_full || pop;
    assign complete  = (state_q == FETCH_ACCESS) && (wait_q == WAIT_LAST)
                       && slot_free && !redirect_i;

    assign wr_entry = '{pc: pc_q, inst: dout};

    // Fetch FSM, PC and wait-state counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_ADDR;
            wait_q  <= 2'd0;
            cs_q    <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    state_q <= FETCH_ACCESS;
                    cs_q    <= 1'b1;
                    oe_q    <= 1'b1;
                    wait_q  <= 2'd0;
                    if (redirect_i) begin
                        pc_q <= word_align(redirect_pc_i);
                    end
                end
                FETCH_ACCESS: begin
                    cs_q <= 1'b1;
                    oe_q <= 1'b1;
                    if (redirect_i) begin
                        pc_q   <= word_align(redirect_pc_i);
                        wait_q <= 2'd0;
                    end else if (complete) begin
                        pc_q   <= next_pc(pc_q);
                        wait_q <= 2'd0;
                    end else if (wait_q != WAIT_LAST) begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
            endcase
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_i),
        .push       (complete),
        .wr_entry   (wr_entry),
        .pop        (pop),
        .head_valid (buf_valid),
        .head       (buf_head),
        .full       (buf_full)
    );

    assign cs           = cs_q;
    assign oe           = oe_q;
    assign we           = 1'b0;
    assign din          = '0;
    assign addr         = pc_q;
    assign inst_valid_o = buf_valid;
    assign inst_o       = buf_head.inst;
    assign pc_o         = buf_head.pc;

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: three instances (WAIT_CYCLES 0, 2, 3)
// each with a combinational sram model, checked on the falling edge.
module tb_imem_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef IMEM_FETCH_PREFETCH_EN
    localparam logic [31:0] ADDR_BP = 32'h0040_0028;
`else
    localparam logic [31:0] ADDR_BP = 32'h0040_0024;
`endif

    function automatic logic [31:0] sram_rd(input logic [31:0] a);
        case (a)
            32'h0040_0020: return 32'h2001_AAAA;
            32'h0040_0024: return 32'h0022_1026;
            32'h0040_0028: return 32'h2822_0A0A;
            32'h0040_002C: return 32'h1440_FFF0;
            default:       return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- instance 0: WAIT_CYCLES = 0 ----------------
    logic        reset0 = 1'b1, redir0 = 1'b0, rdy0 = 1'b1;
    logic [31:0] rpc0 = '0;
    logic        cs0, oe0, we0, val0;
    logic [31:0] addr0, din0, dout0, inst0, pc0;
    assign dout0 = sram_rd(addr0);

    imem_fetch #(.RESET_PC(32'h0040_0020), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset0), .cs(cs0), .oe(oe0), .we(we0), .addr(addr0),
        .din(din0), .dout(dout0), .redirect_i(redir0), .redirect_pc_i(rpc0),
        .inst_valid_o(val0), .inst_ready_i(rdy0), .inst_o(inst0), .pc_o(pc0)
    );

    // ---------------- instance 2: WAIT_CYCLES = 2 ----------------
    logic        reset2 = 1'b1, redir2 = 1'b0, rdy2 = 1'b1;
    logic [31:0] rpc2 = '0;
    logic        cs2, oe2, we2, val2;
    logic [31:0] addr2, din2, dout2, inst2, pc2;
    assign dout2 = sram_rd(addr2);

    imem_fetch #(.RESET_PC(32'h0040_0020), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset2), .cs(cs2), .oe(oe2), .we(we2), .addr(addr2),
        .din(din2), .dout(dout2), .redirect_i(redir2), .redirect_pc_i(rpc2),
        .inst_valid_o(val2), .inst_ready_i(rdy2), .inst_o(inst2), .pc_o(pc2)
    );

    // ---------------- instance 3: WAIT_CYCLES = 3 ----------------
    logic        reset3 = 1'b1, redir3 = 1'b0, rdy3 = 1'b0;
    logic [31:0] rpc3 = '0;
    logic        cs3, oe3, we3, val3;
    logic [31:0] addr3, din3, dout3, inst3, pc3;
    assign dout3 = sram_rd(addr3);

    imem_fetch #(.RESET_PC(32'h0040_0020), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset3), .cs(cs3), .oe(oe3), .we(we3), .addr(addr3),
        .din(din3), .dout(dout3), .redirect_i(redir3), .redirect_pc_i(rpc3),
        .inst_valid_o(val3), .inst_ready_i(rdy3), .inst_o(inst3), .pc_o(pc3)
    );

    task automatic expect_word0(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, {31'd0, val0}, 32'd1);
        check({tag, ".pc"}, pc0, pc);
        check({tag, ".inst"}, inst0, sram_rd(pc));
    endtask

    initial begin
        logic [31:0] addr_tab [10];
        logic        vld_tab  [10];
        logic [31:0] pc_tab   [10];
        addr_tab = '{32'h0040_0020, 32'h0040_0020, 32'h0040_0020,
                     32'h0040_0024, 32'h0040_0024, 32'h0040_0024,
                     32'h0040_0028, 32'h0040_0028, 32'h0040_0028,
                     32'h0040_002C};
        vld_tab  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        pc_tab   = '{32'h0, 32'h0, 32'h0, 32'h0040_0020, 32'h0, 32'h0,
                     32'h0040_0024, 32'h0, 32'h0, 32'h0040_0028};

        repeat (2) @(negedge clk);

        // Reset values.
        check("rst.cs",    {31'd0, cs0}, 32'd0);
        check("rst.oe",    {31'd0, oe0}, 32'd0);
        check("rst.we",    {31'd0, we0}, 32'd0);
        check("rst.din",   din0, 32'd0);
        check("rst.addr",  addr0, 32'h0040_0020);
        check("rst.valid", {31'd0, val0}, 32'd0);
        check("rst.inst",  inst0, 32'd0);
        check("rst.pc",    pc0, 32'd0);

        // Streaming, decode always ready.
        reset0 = 1'b0;
        @(negedge clk);
        check("stream.first_cs",    {31'd0, cs0}, 32'd1);
        check("stream.first_addr",  addr0, 32'h0040_0020);
        check("stream.first_valid", {31'd0, val0}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            expect_word0($sformatf("stream%0d", k), 32'h0040_0020 + 32'(4 * k));
            check($sformatf("stream%0d.cs", k), {31'd0, cs0}, 32'd1);
            check($sformatf("stream%0d.oe", k), {31'd0, oe0}, 32'd1);
            check($sformatf("stream%0d.we", k), {31'd0, we0}, 32'd0);
        end

        // Back-pressure: decode stalls for 5 valid cycles.
        reset0 = 1'b1;
        rdy0   = 1'b0;
        @(negedge clk);
        reset0 = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            expect_word0($sformatf("bp_hold%0d", k), 32'h0040_0020);
        end
        check("bp.addr", addr0, ADDR_BP);
        check("bp.cs",   {31'd0, cs0}, 32'd1);
        rdy0 = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            expect_word0($sformatf("bp_rel%0d", k), 32'h0040_0020 + 32'(4 * k));
        end

        // Redirect to a misaligned target while the buffer is full.
        rdy0 = 1'b0;
        repeat (3) @(negedge clk);
        redir0 = 1'b1;
        rpc0   = 32'h0040_002E;
        @(negedge clk);
        redir0 = 1'b0;
        check("redir_full.valid", {31'd0, val0}, 32'd0);
        check("redir_full.addr",  addr0, 32'h0040_002C);
        @(negedge clk);
        check("redir_full.pc",   pc0, 32'h0040_002C);
        check("redir_full.inst", inst0, 32'h1440_FFF0);
        check("redir_full.val",  {31'd0, val0}, 32'd1);

        // Redirect and pop in the same cycle: the flush wins.
        rdy0   = 1'b1;
        redir0 = 1'b1;
        rpc0   = 32'h0040_0024;
        @(negedge clk);
        redir0 = 1'b0;
        check("redir_pop.valid", {31'd0, val0}, 32'd0);
        check("redir_pop.addr",  addr0, 32'h0040_0024);
        @(negedge clk);
        expect_word0("redir_pop.w0", 32'h0040_0024);
        @(negedge clk);
        expect_word0("redir_pop.w1", 32'h0040_0028);

        // Wrap at the top of the address space.
        redir0 = 1'b1;
        rpc0   = 32'hFFFF_FFFC;
        @(negedge clk);
        redir0 = 1'b0;
        check("wrap.addr_top", addr0, 32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap.addr_zero", addr0, 32'h0000_0000);
        check("wrap.pc",        pc0, 32'hFFFF_FFFC);
        check("wrap.inst",      inst0, 32'hA5A5_A5A6);

        // Wait states: 3 cycles per word.
        reset2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("ws%0d.addr", i),  addr2, addr_tab[i]);
            check($sformatf("ws%0d.valid", i), {31'd0, val2}, {31'd0, vld_tab[i]});
            if (vld_tab[i]) begin
                check($sformatf("ws%0d.pc", i),   pc2, pc_tab[i]);
                check($sformatf("ws%0d.inst", i), inst2, sram_rd(pc_tab[i]));
            end
        end

        // Reset in the middle of a 4-cycle access.
        reset3 = 1'b0;
        repeat (5) @(negedge clk);
        check("mid.valid", {31'd0, val3}, 32'd1);
        check("mid.pc",    pc3, 32'h0040_0020);
        check("mid.addr",  addr3, 32'h0040_0024);
        @(negedge clk);
        reset3 = 1'b1;
        @(negedge clk);
        check("mid_rst.cs",    {31'd0, cs3}, 32'd0);
        check("mid_rst.oe",    {31'd0, oe3}, 32'd0);
        check("mid_rst.we",    {31'd0, we3}, 32'd0);
        check("mid_rst.din",   din3, 32'd0);
        check("mid_rst.addr",  addr3, 32'h0040_0020);
        check("mid_rst.valid", {31'd0, val3}, 32'd0);
        check("mid_rst.inst",  inst3, 32'd0);
        check("mid_rst.pc",    pc3, 32'd0);
        reset3 = 1'b0;
        rdy3   = 1'b1;
        @(negedge clk);
        check("restart.cs",   {31'd0, cs3}, 32'd1);
        check("restart.addr", addr3, 32'h0040_0020);
        repeat (3) @(negedge clk);
        check("restart.early_valid", {31'd0, val3}, 32'd0);
        @(negedge clk);
        check("restart.valid", {31'd0, val3}, 32'd1);
        check("restart.pc",    pc3, 32'h0040_0020);
        check("restart.inst",  inst3, 32'h2001_AAAA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
